// File: rtl/bcd_4digits_to_bin_if.sv
// Handshake and data bundle for bcd_4digits_to_bin.
// Signals:
//   start             conversion request (master -> slave)
//   D_mi/D_ce/D_de/D_un  thousands/hundreds/tens/units BCD digits (master -> slave)
//   bin_out           14-bit binary result, held until next completion (slave -> master)
//   busy              high while the converter is shifting (slave -> master)
//   done              one-cycle completion pulse (slave -> master)
//   err               invalid-digit flag of the last conversion (slave -> master)
interface bcd_4digits_to_bin_if;
  logic        start;
  logic [3:0]  D_un;
  logic [3:0]  D_de;
  logic [3:0]  D_ce;
  logic [3:0]  D_mi;
  logic [13:0] bin_out;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, D_un, D_de, D_ce, D_mi,
    input  bin_out, busy, done, err
  );

  modport slave (
    input  start, D_un, D_de, D_ce, D_mi,
    output bin_out, busy, done, err
  );
endinterface

// File: rtl/bcd_4digits_to_bin.sv
// Sequential four-digit BCD to 14-bit binary converter (reverse double-dabble,
// one bit per clock, 14 clocks per conversion).
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bif    bcd_4digits_to_bin_if.slave (start, digits in; bin_out/busy/done/err out)
// Optional feature macro: BCD_DIGIT_CHECK_EN -- digits > 9 abort straight to
// DONE with bin_out=0 and err=1; when undefined err is tied low.
module bcd_4digits_to_bin (
  input logic                 clk,
  input logic                 rst_n,
  bcd_4digits_to_bin_if.slave bif
);

  localparam int unsigned DigW  = 4;
  localparam int unsigned NDig  = 4;
  localparam int unsigned BinW  = 14;
  localparam int unsigned WorkW = 30;
  localparam int unsigned CntW  = 4;
  localparam logic [CntW-1:0] LastCnt = CntW'(BinW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WorkW-1:0]   work_q, work_d;
  logic [WorkW-1:0]   shifted;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BinW-1:0]    bin_q, bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

`ifdef BCD_DIGIT_CHECK_EN
  logic               err_q, err_d;
  logic               digit_bad;

  assign digit_bad = (bif.D_un > 4'd9) || (bif.D_de > 4'd9) ||
                     (bif.D_ce > 4'd9) || (bif.D_mi > 4'd9);
`endif

  // One reverse double-dabble step: shift right, then pull each BCD nibble
  // that now holds >= 8 back by 3 (a digit's LSB arriving as 8 is worth 5).
  always_comb begin
    shifted = work_q >> 1;
    for (int i = 0; i < NDig; i++) begin
      if (shifted[BinW + i*DigW +: DigW] >= 4'd8) begin
        shifted[BinW + i*DigW +: DigW] = shifted[BinW + i*DigW +: DigW] - 4'd3;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BCD_DIGIT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bif.start) begin
`ifdef BCD_DIGIT_CHECK_EN
          state_d = digit_bad ? DONE : SHIFT;
`else
          state_d = SHIFT;
`endif
        end
      end
      SHIFT:   if (cnt_q == LastCnt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
`ifdef BCD_DIGIT_CHECK_EN
    err_d  = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bif.start) begin
          // Thousands in the top nibble down to units just above the bin field.
          work_d = {bif.D_mi, bif.D_ce, bif.D_de, bif.D_un, BinW'(0)};
          cnt_d  = '0;
`ifdef BCD_DIGIT_CHECK_EN
          if (digit_bad) begin
            bin_d = '0;
            err_d = 1'b1;
          end
`endif
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          bin_d = shifted[BinW-1:0];
`ifdef BCD_DIGIT_CHECK_EN
          err_d = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  assign bif.bin_out = bin_q;
  assign bif.busy    = busy_q;
  assign bif.done    = done_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign bif.err     = err_q;
`else
  assign bif.err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_4digits_to_bin.sv
// Self-checking bench for bcd_4digits_to_bin: directed handshake/timing steps
// plus random valid digit sets checked against decimal arithmetic.
module tb_bcd_4digits_to_bin;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  bcd_4digits_to_bin_if bif ();

  bcd_4digits_to_bin dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ref_value(input logic [3:0] mi, ce, de, un);
    return 1000 * int'(mi) + 100 * int'(ce) + 10 * int'(de) + int'(un);
  endfunction

  task automatic set_digits(input logic [3:0] mi, ce, de, un);
    bif.D_mi = mi;
    bif.D_ce = ce;
    bif.D_de = de;
    bif.D_un = un;
  endtask

  // One full conversion; disturb scrambles digits and pulses start while busy/done.
  task automatic run_conv(input logic [3:0] mi, ce, de, un, input bit disturb);
    int unsigned expv;
    expv = ref_value(mi, ce, de, un);
    set_digits(mi, ce, de, un);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("busy_in_shift", 32'(bif.busy), 32'd1);
      check("done_in_shift", 32'(bif.done), 32'd0);
      if (disturb) begin
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        bif.start = (i % 3 == 0);
      end
      step();
    end
    check("done_pulse", 32'(bif.done), 32'd1);
    check("busy_at_done", 32'(bif.busy), 32'd0);
    check("bin_out", 32'(bif.bin_out), 32'(expv));
    check("err_valid", 32'(bif.err), 32'd0);
    if (disturb) bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    check("done_falls", 32'(bif.done), 32'd0);
    check("busy_after_done", 32'(bif.busy), 32'd0);
    check("bin_out_held", 32'(bif.bin_out), 32'(expv));
    if (disturb) begin
      step();
      check("start_in_done_ignored", 32'(bif.busy), 32'd0);
    end
  endtask

  initial begin
    bif.start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    check("rst_bin_out", 32'(bif.bin_out), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_err", 32'(bif.err), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic conversion 1234
    run_conv(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);

    // Back-to-back 9999 then 0000 with start held high
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    bif.start = 1'b1;
    step();
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 1; i < 14; i++) step();
    step();
    check("b2b_done1", 32'(bif.done), 32'd1);
    check("b2b_bin1", 32'(bif.bin_out), 32'd9999);
    step();
    check("b2b_done1_falls", 32'(bif.done), 32'd0);
    check("b2b_idle_gap", 32'(bif.busy), 32'd0);
    step();
    check("b2b_reaccept", 32'(bif.busy), 32'd1);
    bif.start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    check("b2b_no_early_done", 32'(bif.done), 32'd0);
    step();
    check("b2b_done2", 32'(bif.done), 32'd1);
    check("b2b_bin2", 32'(bif.bin_out), 32'd0);
    step();

    // Digits changed during SHIFT and start pulses in SHIFT/DONE are ignored
    run_conv(4'd0, 4'd0, 4'd1, 4'd0, 1'b1);
    run_conv(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);

    // Reset mid-conversion; reset wins over a simultaneous start
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_busy_before_rst", 32'(bif.busy), 32'd1);
    rst_n = 1'b0;
    bif.start = 1'b1;
    step();
    check("mid_rst_bin_out", 32'(bif.bin_out), 32'd0);
    check("mid_rst_busy", 32'(bif.busy), 32'd0);
    check("mid_rst_done", 32'(bif.done), 32'd0);
    rst_n = 1'b1;
    bif.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("no_done_after_rst", 32'(bif.done), 32'd0);
    end
    run_conv(4'd5, 4'd6, 4'd7, 4'd8, 1'b0);

    // Invalid digit
    set_digits(4'd0, 4'd0, 4'd0, 4'hA);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    check("bad_done_fast", 32'(bif.done), 32'd1);
    check("bad_err", 32'(bif.err), 32'd1);
    check("bad_bin_out", 32'(bif.bin_out), 32'd0);
    check("bad_busy", 32'(bif.busy), 32'd0);
    step();
    check("bad_done_falls", 32'(bif.done), 32'd0);
    check("bad_busy_idle", 32'(bif.busy), 32'd0);
`else
    for (int i = 0; i < 14; i++) begin
      check("bad_busy_shift", 32'(bif.busy), 32'd1);
      check("bad_done_shift", 32'(bif.done), 32'd0);
      step();
    end
    check("bad_done_late", 32'(bif.done), 32'd1);
    check("bad_err_tied", 32'(bif.err), 32'd0);
    step();
`endif
    // A valid conversion clears err
    run_conv(4'd4, 4'd0, 4'd9, 4'd6, 1'b0);

    // Random valid digit sets
    for (int n = 0; n < 20; n++) begin
      run_conv(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), n[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
